btn_debouncer: RTL
==================

// Module: btn_debouncer
// PURPOSE
//  Conditions raw FPGA push-button inputs before they reach the button peripheral (btn) behind the Bridge.
//  Synchronises each asynchronous pin, filters contact bounce and flags each debounced press with a one-cycle pulse.
//  Its debounced level output drives the btn peripheral's button input; it runs on cpu_clk.
// PARAMETERS
//  N_BTN        5       number of buttons (matches board button[4:0])
//  SYNC_STAGES  2       flip-flop synchroniser depth per button, >=2
//  DB_CYCLES    200000  consecutive stable cycles required to accept a new level, >=2
//  CNT_W        18      debounce counter width; must satisfy 2**CNT_W > DB_CYCLES
// PORTS
//  clk         in   1      cpu_clk
//  rst         in   1      synchronous reset, active-high
//  button_raw  in   N_BTN  raw board pins, asynchronous to clk
//  btn_stable  out  N_BTN  debounced level, registered
//  btn_press   out  N_BTN  one-cycle pulse on a debounced 0->1 edge, registered
//  btn_clr     in   N_BTN  clears the matching btn_pending bit (ignored when BTN_PENDING_EN is undefined)
//  btn_pending out  N_BTN  sticky press flags (tied to 0 when BTN_PENDING_EN is undefined)
// BEHAVIOUR
//  Reset: all sync flops, counters, btn_stable, btn_press and btn_pending are 0; the FSM enters S_LOW. Reset overrides everything.
//  Sync: button_raw[i] passes through SYNC_STAGES flops to give s[i]. There is no combinational path from button_raw to any output.
//  Per-button FSM, 2-bit state:
//   S_LOW:  stable=0. If s=1, go to S_RISE and set cnt=1; otherwise cnt=0.
//   S_RISE: if s=0, return to S_LOW and set cnt=0.
//           Else if cnt==DB_CYCLES-1, go to S_HIGH, set stable=1, pulse press=1 for 1 cycle, set cnt=0.
//           Else cnt++.
//   S_HIGH: stable=1. If s=0, go to S_FALL and set cnt=1.
//   S_FALL: if s=1, return to S_HIGH and set cnt=0.
//           Else if cnt==DB_CYCLES-1, go to S_LOW, set stable=0, set cnt=0. No pulse on release.
//  Latency: button_raw edge to btn_stable/btn_press = SYNC_STAGES + DB_CYCLES cycles, provided the level is held throughout.
//  A level held for fewer than DB_CYCLES synchronised cycles is discarded; btn_stable does not change.
//  Each bounce restarts the count; exactly one press pulse occurs per accepted rising edge.
//  The counter never exceeds DB_CYCLES-1, so it cannot wrap. Buttons are fully independent, and simultaneous presses give simultaneous pulses.
//  rst asserted mid-count discards the partial count. After rst is released, a held button is re-qualified from S_LOW and produces a press pulse.
// CONFIGURATION
//  BTN_PENDING_EN defined:
//   - btn_pending[i] is set the cycle after btn_press[i].
//   - btn_pending[i] is cleared the cycle after btn_clr[i]=1.
//   - Set and clear in the same cycle: set wins.
//  BTN_PENDING_EN undefined: btn_pending is constant 0, btn_clr is unused and no pending flops are built.
// STRUCTURE
//  defines.vh holds the state encodings (S_LOW=2'd0, S_RISE=2'd1, S_HIGH=2'd2, S_FALL=2'd3) and the default DB_CYCLES constant.
//  Sub-module btn_db_cell holds one button's synchroniser, counter and FSM. It is instantiated N_BTN times with a generate loop.
//  The top level adds only the optional pending logic.
// TESTING (bench uses DB_CYCLES=8, SYNC_STAGES=2, so latency = 10 cycles)
//  1 Reset: assert rst with button_raw=5'b11111 -> all outputs 0 while rst is high. After release, btn_stable=5'b11111 and btn_press=5'b11111 after 10 cycles.
//  2 Clean press: raw[0] goes 0->1 and is held 20 cycles -> btn_stable[0] rises exactly 10 cycles later; btn_press[0]=1 for that cycle only.
//  3 Bounce: raw[1] toggles every 3 cycles for 30 cycles, then holds 1 -> a single press pulse, 10 cycles after the final edge.
//  4 Glitch: raw[2] is high for 7 cycles, then 0 -> btn_stable[2] and btn_press[2] stay 0.
//  5 Release/reset: held button, raw goes 0 -> stable falls after 10 cycles with no pulse.
//    Assert rst at cnt=5 -> cnt=0 and state S_LOW.
//  6 Pending (BTN_PENDING_EN): press raw[3] -> btn_pending[3]=1.
//    Assert btn_clr[3] in the cycle a second press pulse occurs -> btn_pending[3] stays 1.
//    Assert btn_clr[3] alone -> btn_pending[3]=0 on the next cycle.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// btn_debouncer_pkg
// Shared definitions for the push-button conditioning block:
//   - db_state_e : per-button debounce FSM state encoding
//   - default parameter values for the debouncer
//   - pending_next() : next value of one sticky press flag
// -----------------------------------------------------------------------------
package btn_debouncer_pkg;

    // Debounce FSM states; the encoding is shared by every button cell.
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } db_state_e;

    localparam int N_BTN_DEF       = 5;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DB_CYCLES_DEF   = 200000;
    localparam int CNT_W_DEF       = 18;

    // Sticky flag update: a new press always wins over a simultaneous clear.
    function automatic logic pending_next(input logic pend, input logic press, input logic clr);
        return press | (pend & ~clr);
    endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// -----------------------------------------------------------------------------
// btn_debouncer_if
// Groups the button-side signals of the debouncer.
//   button_raw  : raw board pins, asynchronous to clk
//   btn_clr     : per-button clear of the sticky pending flag
//   btn_stable  : debounced level
//   btn_press   : one-cycle pulse on each accepted rising edge
//   btn_pending : sticky press flags (constant 0 unless BTN_PENDING_EN)
// The debouncer connects through the slave modport; the board/bus side
// driving it uses master.
// -----------------------------------------------------------------------------
interface btn_debouncer_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] button_raw;
    logic [N_BTN-1:0] btn_clr;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_pending;

    modport master (
        output button_raw,
        output btn_clr,
        input  btn_stable,
        input  btn_press,
        input  btn_pending
    );

    modport slave (
        input  button_raw,
        input  btn_clr,
        output btn_stable,
        output btn_press,
        output btn_pending
    );
endinterface

// File: rtl/btn_debouncer_db_cell.sv
// -----------------------------------------------------------------------------
// btn_db_cell
// One button's synchroniser, stability counter and debounce FSM.
//   clk         in  cpu_clk
//   rst         in  synchronous reset, active-high
//   button_raw  in  raw pin, asynchronous to clk
//   btn_stable  out debounced level, registered
//   btn_press   out one-cycle pulse on an accepted 0->1 edge, registered
// A new level is accepted only after DB_CYCLES consecutive synchronised
// samples agree; any disagreement returns to the settled state and the count
// restarts on the next edge.
// -----------------------------------------------------------------------------
module btn_db_cell
    import btn_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic btn_stable,
    output logic btn_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    db_state_e              state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   press_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chain for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], button_raw};
        end
    end

    // Debounce FSM with counter; stable and press are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_LOW;
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
            press_r  <= 1'b0;
        end else begin
            press_r <= 1'b0;
            case (state_r)
                S_LOW: begin
                    stable_r <= 1'b0;
                    if (sync_s) begin
                        state_r <= S_RISE;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                S_RISE: begin
                    if (!sync_s) begin
                        state_r <= S_LOW;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= S_HIGH;
                        stable_r <= 1'b1;
                        press_r  <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    stable_r <= 1'b1;
                    if (!sync_s) begin
                        state_r <= S_FALL;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                S_FALL: begin
                    if (sync_s) begin
                        state_r <= S_HIGH;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= S_LOW;
                        stable_r <= 1'b0;
                        cnt_r    <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r  <= S_LOW;
                    cnt_r    <= CNT_ZERO;
                    stable_r <= 1'b0;
                end
            endcase
        end
    end

    assign btn_stable = stable_r;
    assign btn_press  = press_r;

endmodule

// File: rtl/btn_debouncer.sv
// -----------------------------------------------------------------------------
// btn_debouncer (top)
// Conditions N_BTN raw push-button pins for the btn peripheral on cpu_clk.
//   clk   in  cpu_clk
//   rst   in  synchronous reset, active-high
//   bus   slave modport of btn_debouncer_if:
//         button_raw (in), btn_clr (in), btn_stable (out), btn_press (out),
//         btn_pending (out)
// Optional feature macro: BTN_PENDING_EN
//   defined   : btn_pending[i] is a sticky flag set by btn_press[i] and
//               cleared by btn_clr[i] (set wins on collision)
//   undefined : btn_pending is constant 0 and btn_clr is ignored
// -----------------------------------------------------------------------------
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    btn_debouncer_if.slave bus
);

    logic [N_BTN-1:0] stable_s;
    logic [N_BTN-1:0] press_s;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_cell
        btn_db_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .button_raw (bus.button_raw[gi]),
            .btn_stable (stable_s[gi]),
            .btn_press  (press_s[gi])
        );
    end

    assign bus.btn_stable = stable_s;
    assign bus.btn_press  = press_s;

`ifdef BTN_PENDING_EN
    logic [N_BTN-1:0] pending_r;

    // Sticky pending flags, one per button.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {N_BTN{1'b0}};
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                pending_r[i] <= pending_next(pending_r[i], press_s[i], bus.btn_clr[i]);
            end
        end
    end

    assign bus.btn_pending = pending_r;
`else
    logic unused_clr_s;

    assign unused_clr_s    = ^bus.btn_clr;
    assign bus.btn_pending = {N_BTN{1'b0}};
`endif

endmodule
